bw_clk_gclk_stop_seq: RTL and testbench
=======================================

Name: bw_clk_gclk_stop_seq

Overview:
Sequencer at the receiving end of the global clock tree that stops and restarts per-cluster clocks in a staggered order. Staggering bounds di/dt on the grid. It takes a level stop request from the clock controller and drives one clock-enable per cluster header. It acknowledges once every cluster is stopped. Restart runs in reverse order with the same spacing.

Parameters:
NCLU, 4, number of cluster clock enables driven (>=2)
DLY_W, 4, width of the programmable inter-cluster delay

Ports:
gclk  input  1  global clock; all state on its rising edge
grst  input  1  synchronous reset, active-high
stop_req  input  1  level request: 1 = stop all clusters, 0 = run
stop_dly  input  DLY_W  extra cycles between successive cluster transitions
clken  output  NCLU  per-cluster clock enable, 1 = clock running
stop_ack  output  1  1 while all clusters are stopped (state STOPPED)
busy  output  1  1 while a stop or start sequence is in progress

Behaviour:
- All outputs are registered. No combinational path from any input to any output.
- Reset (grst=1 at an edge):
  - state=RUN; clken all 1s; stop_ack=0; busy=0.
  - Internal counter cnt=0 and index idx=0.
  - Reset overrides any in-progress sequence: all clusters are re-enabled on that edge.
- State machine: RUN, STOPPING, STOPPED, STARTING.
- RUN:
  - If stop_req=1 at edge k: go to STOPPING, busy=1, idx=0, cnt=stop_dly.
- STOPPING:
  - cnt!=0: decrement cnt.
  - cnt==0: clear clken[idx].
    - If idx==NCLU-1: go to STOPPED, busy=0, stop_ack=1.
    - Otherwise: idx++, cnt=stop_dly (resampled at each reload).
- Stop timing:
  - clken[0] falls at edge k+stop_dly+1.
  - clken[i] falls at edge k+(i+1)*(stop_dly+1).
  - stop_ack rises on the same edge that clears clken[NCLU-1].
  - With stop_dly=0, one cluster stops per cycle.
- STOPPED:
  - Hold while stop_req=1.
  - On stop_req=0: go to STARTING, stop_ack=0, busy=1, idx=NCLU-1, cnt=stop_dly.
- STARTING:
  - Mirror of STOPPING, but sets clken[idx] and decrements idx (LIFO order).
  - After clken[0] is set: go to RUN, busy=0.
- No abort:
  - stop_req deasserting during STOPPING does not stop the sequence. It completes, enters STOPPED for at least one cycle, then starts.
  - stop_req reasserting during STARTING is ignored until RUN. A new stop sequence then begins on the next edge.
- Invariants:
  - clken only ever changes one bit per edge, except on reset.
  - In STOPPING, clken[j]=0 for all j<idx.
  - In STARTING, clken[j]=0 for all j<=idx.
  - stop_ack and busy are never both 1.
- Arithmetic:
  - cnt is DLY_W bits, never wraps: decrements are only taken when cnt!=0.
  - idx is clog2(NCLU) bits and stays within 0..NCLU-1.

Optional Feature:
Macro: BW_CLK_GCLK_STEP_EN.
- Defined:
  - Adds input port step (1 bit).
  - In STOPPED, a 0->1 transition of step (registered edge detect) drives clken to all 1s for exactly one cycle, then back to all 0s.
  - step is ignored in all other states.
  - Holding step high gives a single pulse.
  - If stop_req falls on the same edge as the step pulse, the step pulse is dropped and STARTING begins normally.
  - stop_ack stays 1 during a step pulse.
- Undefined: step port and its logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset then idle, stop_req=0 for 20 cycles -> clken=4'b1111, stop_ack=0, busy=0 throughout.
- stop_dly=2, stop_req rises, sampled at edge k -> clken bits 0..3 fall at k+3, k+6, k+9, k+12; stop_ack=1 and busy=0 from k+12.
- From STOPPED with stop_dly=0, drop stop_req at edge m -> stop_ack=0 at m; clken bits 3,2,1,0 rise at m+1..m+4; busy=0 after m+4.
- stop_dly=1, pulse stop_req high for 1 cycle -> full stop completes (ack at k+8), then STARTING; clken=4'b1111 again at k+17.
- grst asserted mid-STOPPING (clken=4'b1100) -> next edge clken=4'b1111, busy=0, stop_ack=0, state RUN.
- With BW_CLK_GCLK_STEP_EN, in STOPPED, hold step high 5 cycles -> clken=4'b1111 for exactly one cycle, then 4'b0000; stop_ack stays 1.

Source files
------------

// File: rtl/bw_clk_gclk_stop_seq.sv
// Staggered stop/restart sequencer for per-cluster clock enables on the global clock tree.
// Optional single-cycle clock step while stopped: define BW_CLK_GCLK_STEP_EN.
module bw_clk_gclk_stop_seq #(
  parameter int NCLU  = 4,
  parameter int DLY_W = 4
) (
  input  logic             gclk,
  input  logic             grst,
  input  logic             stop_req,
  input  logic [DLY_W-1:0] stop_dly,
`ifdef BW_CLK_GCLK_STEP_EN
  input  logic             step,
`endif
  output logic [NCLU-1:0]  clken,
  output logic             stop_ack,
  output logic             busy
);

  localparam int IDX_W = $clog2(NCLU);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCLU - 1);

  typedef enum logic [1:0] {
    RUN,
    STOPPING,
    STOPPED,
    STARTING
  } state_t;

  state_t           state;
  logic [DLY_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic             step_rise;

`ifdef BW_CLK_GCLK_STEP_EN
  logic step_q;

  always_ff @(posedge gclk) begin
    if (grst) step_q <= 1'b0;
    else      step_q <= step;
  end

  assign step_rise = step & ~step_q;
`else
  assign step_rise = 1'b0;
`endif

  // Stop walks clusters upward, restart walks them back down, one cluster per stop_dly+1 edges.
  always_ff @(posedge gclk) begin
    if (grst) begin
      state    <= RUN;
      clken    <= '1;
      stop_ack <= 1'b0;
      busy     <= 1'b0;
      cnt      <= '0;
      idx      <= '0;
    end else begin
      case (state)
        RUN: begin
          if (stop_req) begin
            state <= STOPPING;
            busy  <= 1'b1;
            idx   <= '0;
            cnt   <= stop_dly;
          end
        end
        STOPPING: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            clken[idx] <= 1'b0;
            if (idx == IDX_LAST) begin
              state    <= STOPPED;
              busy     <= 1'b0;
              stop_ack <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
              cnt <= stop_dly;
            end
          end
        end
        STOPPED: begin
          // Any step pulse lasts one cycle; leaving STOPPED always starts from all-off.
          clken <= '0;
          if (!stop_req) begin
            state    <= STARTING;
            stop_ack <= 1'b0;
            busy     <= 1'b1;
            idx      <= IDX_LAST;
            cnt      <= stop_dly;
          end else if (step_rise) begin
            clken <= '1;
          end
        end
        STARTING: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            clken[idx] <= 1'b1;
            if (idx == '0) begin
              state <= RUN;
              busy  <= 1'b0;
            end else begin
              idx <= idx - 1'b1;
              cnt <= stop_dly;
            end
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_bw_clk_gclk_stop_seq.sv
// Self-checking bench for bw_clk_gclk_stop_seq against a timeline-based reference model.
module tb_bw_clk_gclk_stop_seq;

  localparam int NCLU  = 4;
  localparam int DLY_W = 4;

  logic             gclk;
  logic             grst;
  logic             stop_req;
  logic [DLY_W-1:0] stop_dly;
  logic [NCLU-1:0]  clken;
  logic             stop_ack;
  logic             busy;
`ifdef BW_CLK_GCLK_STEP_EN
  logic             step;
`endif

  int checks = 0;
  int errors = 0;

  // Model: mode 0=run 1=stopping 2=stopped 3=starting; progress derived from elapsed edges.
  int              m_mode = 0;
  int              m_t    = 0;
  int              m_t0   = 0;
  int              m_d    = 0;
  bit              m_pulse = 0;
  bit              m_step_prev = 0;
  logic [NCLU-1:0] exp_clken;
  logic            exp_ack;
  logic            exp_busy;

  bw_clk_gclk_stop_seq #(.NCLU(NCLU), .DLY_W(DLY_W)) dut (
    .gclk     (gclk),
    .grst     (grst),
    .stop_req (stop_req),
    .stop_dly (stop_dly),
`ifdef BW_CLK_GCLK_STEP_EN
    .step     (step),
`endif
    .clken    (clken),
    .stop_ack (stop_ack),
    .busy     (busy)
  );

  initial begin
    gclk = 1'b0;
    forever #5 gclk = ~gclk;
  end

  task automatic model_edge();
    int n;
    m_t++;
    if (grst) begin
      m_mode      = 0;
      m_pulse     = 0;
      m_step_prev = 0;
    end else begin
      m_pulse = 0;
      case (m_mode)
        0: if (stop_req) begin m_mode = 1; m_t0 = m_t; m_d = int'(stop_dly); end
        1: if ((m_t - m_t0) / (m_d + 1) >= NCLU) m_mode = 2;
        2: begin
          if (!stop_req) begin m_mode = 3; m_t0 = m_t; m_d = int'(stop_dly); end
`ifdef BW_CLK_GCLK_STEP_EN
          else if (step && !m_step_prev) m_pulse = 1;
`endif
        end
        3: if ((m_t - m_t0) / (m_d + 1) >= NCLU) m_mode = 0;
        default: m_mode = 0;
      endcase
`ifdef BW_CLK_GCLK_STEP_EN
      m_step_prev = step;
`endif
    end
    n = (m_t - m_t0) / (m_d + 1);
    if (n > NCLU) n = NCLU;
    for (int j = 0; j < NCLU; j++) begin
      case (m_mode)
        0:       exp_clken[j] = 1'b1;
        1:       exp_clken[j] = (j >= n);
        2:       exp_clken[j] = m_pulse;
        default: exp_clken[j] = (j >= NCLU - n);
      endcase
    end
    exp_ack  = (m_mode == 2);
    exp_busy = (m_mode == 1) || (m_mode == 3);
  endtask

  task automatic cycle();
    @(posedge gclk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    grst = 1'b1;
    cycle();
    cycle();
    checks++;
    if ({clken, stop_ack, busy} !== {4'b1111, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset: clken=%b ack=%b busy=%b, expected clken=1111 ack=0 busy=0", clken, stop_ack, busy);
    end
    grst = 1'b0;
  endtask

  task automatic test_idle();
    stop_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      checks++;
      if ({clken, stop_ack, busy} !== {4'b1111, 1'b0, 1'b0}) begin
        errors++;
        $display("[TB] FAIL idle t=%0d: clken=%b ack=%b busy=%b, expected clken=1111 ack=0 busy=0", m_t, clken, stop_ack, busy);
      end
    end
  endtask

  task automatic test_stop_timing();
    stop_dly = 4'd2;
    stop_req = 1'b1;
    for (int i = 0; i <= 12; i++) begin
      cycle();
      checks++;
      if ({clken, stop_ack, busy} !== {exp_clken, exp_ack, exp_busy}) begin
        errors++;
        $display("[TB] FAIL stop_timing k+%0d: clken=%b ack=%b busy=%b, expected clken=%b ack=%b busy=%b", i, clken, stop_ack, busy, exp_clken, exp_ack, exp_busy);
      end
      if (i == 6) begin
        checks++;
        if (clken !== 4'b1100 || busy !== 1'b1) begin
          errors++;
          $display("[TB] FAIL stop_timing_k6: clken=%b busy=%b, expected clken=1100 busy=1", clken, busy);
        end
      end
    end
    checks++;
    if ({clken, stop_ack, busy} !== {4'b0000, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL stop_timing_k12: clken=%b ack=%b busy=%b, expected clken=0000 ack=1 busy=0", clken, stop_ack, busy);
    end
  endtask

  task automatic test_start_timing();
    stop_dly = 4'd0;
    stop_req = 1'b0;
    cycle();
    checks++;
    if ({clken, stop_ack, busy} !== {4'b0000, 1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL start_m: clken=%b ack=%b busy=%b, expected clken=0000 ack=0 busy=1", clken, stop_ack, busy);
    end
    for (int i = 1; i <= 4; i++) begin
      cycle();
      checks++;
      if ({clken, stop_ack, busy} !== {exp_clken, exp_ack, exp_busy}) begin
        errors++;
        $display("[TB] FAIL start_timing m+%0d: clken=%b ack=%b busy=%b, expected clken=%b ack=%b busy=%b", i, clken, stop_ack, busy, exp_clken, exp_ack, exp_busy);
      end
    end
    checks++;
    if ({clken, stop_ack, busy} !== {4'b1111, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL start_m4: clken=%b ack=%b busy=%b, expected clken=1111 ack=0 busy=0", clken, stop_ack, busy);
    end
  endtask

  task automatic test_pulse_req();
    stop_dly = 4'd1;
    stop_req = 1'b1;
    cycle();
    stop_req = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      cycle();
      checks++;
      if ({clken, stop_ack, busy} !== {exp_clken, exp_ack, exp_busy}) begin
        errors++;
        $display("[TB] FAIL pulse_req k+%0d: clken=%b ack=%b busy=%b, expected clken=%b ack=%b busy=%b", i, clken, stop_ack, busy, exp_clken, exp_ack, exp_busy);
      end
      if (i == 8) begin
        checks++;
        if (stop_ack !== 1'b1 || clken !== 4'b0000) begin
          errors++;
          $display("[TB] FAIL pulse_req_ack: clken=%b ack=%b, expected clken=0000 ack=1", clken, stop_ack);
        end
      end
    end
    checks++;
    if ({clken, stop_ack, busy} !== {4'b1111, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL pulse_req_k17: clken=%b ack=%b busy=%b, expected clken=1111 ack=0 busy=0", clken, stop_ack, busy);
    end
  endtask

  task automatic test_reset_mid();
    stop_dly = 4'd0;
    stop_req = 1'b1;
    cycle();
    cycle();
    cycle();
    checks++;
    if (clken !== 4'b1100 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_mid_pre: clken=%b busy=%b, expected clken=1100 busy=1", clken, busy);
    end
    stop_req = 1'b0;
    grst = 1'b1;
    cycle();
    checks++;
    if ({clken, stop_ack, busy} !== {4'b1111, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_mid: clken=%b ack=%b busy=%b, expected clken=1111 ack=0 busy=0", clken, stop_ack, busy);
    end
    grst = 1'b0;
    cycle();
    checks++;
    if ({clken, stop_ack, busy} !== {exp_clken, exp_ack, exp_busy}) begin
      errors++;
      $display("[TB] FAIL reset_mid_after: clken=%b ack=%b busy=%b, expected clken=%b ack=%b busy=%b", clken, stop_ack, busy, exp_clken, exp_ack, exp_busy);
    end
  endtask

  task automatic test_back_to_back();
    stop_dly = 4'd0;
    stop_req = 1'b1;
    for (int i = 0; i < 22; i++) begin
      if (i == 5) stop_req = 1'b0;
      if (i == 7) stop_req = 1'b1;
      cycle();
      checks++;
      if ({clken, stop_ack, busy} !== {exp_clken, exp_ack, exp_busy}) begin
        errors++;
        $display("[TB] FAIL back_to_back i=%0d: clken=%b ack=%b busy=%b, expected clken=%b ack=%b busy=%b", i, clken, stop_ack, busy, exp_clken, exp_ack, exp_busy);
      end
    end
  endtask

`ifdef BW_CLK_GCLK_STEP_EN
  task automatic test_step();
    stop_dly = 4'd0;
    stop_req = 1'b1;
    step     = 1'b0;
    for (int i = 0; i < 16; i++) cycle();
    step = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++;
      if ({clken, stop_ack, busy} !== {(i == 0) ? 4'b1111 : 4'b0000, 1'b1, 1'b0}) begin
        errors++;
        $display("[TB] FAIL step i=%0d: clken=%b ack=%b busy=%b, expected single 1111 pulse with ack=1", i, clken, stop_ack, busy);
      end
    end
    step = 1'b0;
    stop_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      checks++;
      if ({clken, stop_ack, busy} !== {exp_clken, exp_ack, exp_busy}) begin
        errors++;
        $display("[TB] FAIL step_restart i=%0d: clken=%b ack=%b busy=%b, expected clken=%b ack=%b busy=%b", i, clken, stop_ack, busy, exp_clken, exp_ack, exp_busy);
      end
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      if ((m_mode == 0 || m_mode == 2) && ($urandom % 4 == 0)) stop_dly = DLY_W'($urandom_range(0, 3));
      if ($urandom % 12 == 0) stop_req = ~stop_req;
      grst = ($urandom % 90 == 0);
`ifdef BW_CLK_GCLK_STEP_EN
      if ($urandom % 3 == 0) step = ~step;
`endif
      cycle();
      checks++;
      if ({clken, stop_ack, busy} !== {exp_clken, exp_ack, exp_busy}) begin
        errors++;
        $display("[TB] FAIL random i=%0d: clken=%b ack=%b busy=%b, expected clken=%b ack=%b busy=%b", i, clken, stop_ack, busy, exp_clken, exp_ack, exp_busy);
      end
    end
    grst = 1'b0;
  endtask

  initial begin
    grst     = 1'b1;
    stop_req = 1'b0;
    stop_dly = '0;
`ifdef BW_CLK_GCLK_STEP_EN
    step     = 1'b0;
`endif
    test_reset();
    test_idle();
    test_stop_timing();
    test_start_timing();
    test_pulse_req();
    test_reset_mid();
    test_back_to_back();
`ifdef BW_CLK_GCLK_STEP_EN
    test_step();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
